// File: rtl/dac_spi.sv
// dac_spi: SPI mode-0 master turning each 16-bit sample into a 24-bit DAC write-and-update frame,
// with a single-entry latest-wins pending buffer in front of the shifter.
module dac_spi #(
    parameter int         CLK_DIV  = 4,
    parameter int         CS_GAP   = 4,
    parameter logic [3:0] DAC_CMD  = 4'b0011,
    parameter logic [3:0] DAC_ADDR = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] samp,
    input  logic        samp_val,
    input  logic        overrun_clr,
    output logic        busy,
    output logic        overrun,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    output logic        dac_cs_n_o
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = CS_GAP > 1 ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_d;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [4:0]    bit_cnt;
    logic          sclk;
    logic [23:0]   sr;
    logic [15:0]   pend_q;
    logic          pend_v;
    logic          load, div_end, gap_end;

    always_comb begin
        div_end = div_cnt == DW'(CLK_DIV - 1);
        gap_end = gap_cnt == GW'(CS_GAP - 1);
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                load    = pend_v;
                state_d = pend_v ? SETUP : IDLE;
            end
            SETUP: state_d = div_end ? SHIFT : SETUP;
            SHIFT: state_d = (div_end && sclk && bit_cnt == 5'd0) ? HOLD : SHIFT;
            HOLD:  state_d = div_end ? GAP : HOLD;
            // the end of the gap acts as IDLE so a pending sample starts without a spare cycle
            GAP: begin
                load    = gap_end && pend_v;
                state_d = !gap_end ? GAP : pend_v ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            sclk       <= 1'b0;
            sr         <= '0;
            pend_q     <= '0;
            pend_v     <= 1'b0;
            overrun    <= 1'b0;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            dac_cs_n_o <= 1'b1;
        end else begin
            div_cnt <= (state_d != state || div_end) ? '0 : div_cnt + 1'b1;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (load) begin
                sr      <= {DAC_CMD, DAC_ADDR, pend_q};
                bit_cnt <= 5'd23;
            end else if (state == SHIFT && div_end) begin
                sclk <= ~sclk;
                // falling edge: present the next bit, except after the last one
                if (sclk && bit_cnt != 5'd0) begin
                    sr      <= {sr[22:0], 1'b0};
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end
            pend_v  <= samp_val | (pend_v & ~load);
            if (samp_val) pend_q <= samp;
            overrun <= (samp_val & pend_v & ~load) | (overrun & ~overrun_clr);
            spi_clk_o  <= sclk;
            spi_mosi_o <= sr[23];
            dac_cs_n_o <= state == IDLE || state == GAP;
        end
    end

    assign busy = (state != IDLE) | pend_v;
endmodule
